// File: rtl/reset_sequencer.sv
// Staged reset-release controller: stretches reset, waits for lock,
// then releases active-low resets one by one with a fixed gap.
module reset_sequencer #(
  parameter int N_OUT   = 4,
  parameter int STRETCH = 16,
  parameter int GAP     = 8
) (
  input  logic             clk,
  input  logic             i_rst_async,
  input  logic             i_lock,
  input  logic             i_sw_rst,
  output logic [N_OUT-1:0] o_rst_n,
  output logic             o_done,
  output logic             o_lock_lost
);

  localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    scnt, scnt_nx;
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic [NW-1:0]    stage, stage_nx;
  logic [N_OUT-1:0] rst_nx;
  logic             done_nx;
  logic             lost_nx;
  logic             good;

  assign good = i_lock && !i_sw_rst;

  always_ff @(posedge clk or negedge i_rst_async) begin
    if (!i_rst_async) begin
      state       <= HOLD;
      scnt        <= '0;
      gcnt        <= '0;
      stage       <= '0;
      o_rst_n     <= '0;
      o_done      <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state       <= state_nx;
      scnt        <= scnt_nx;
      gcnt        <= gcnt_nx;
      stage       <= stage_nx;
      o_rst_n     <= rst_nx;
      o_done      <= done_nx;
      o_lock_lost <= lost_nx;
    end
  end

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    gcnt_nx  = gcnt;
    stage_nx = stage;
    rst_nx   = o_rst_n;
    done_nx  = o_done;
    lost_nx  = 1'b0;
    if (state != HOLD && !good) begin
      // lock loss takes priority in reporting even with sw reset high
      state_nx = HOLD;
      scnt_nx  = '0;
      gcnt_nx  = '0;
      stage_nx = '0;
      rst_nx   = '0;
      done_nx  = 1'b0;
      lost_nx  = !i_lock;
    end else begin
      unique case (state)
        HOLD: begin
          if (!good) begin
            scnt_nx = '0;
          end else if (scnt == SW'(STRETCH - 1)) begin
            scnt_nx   = '0;
            gcnt_nx   = '0;
            stage_nx  = NW'(1);
            rst_nx[0] = 1'b1;
            if (N_OUT == 1) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              state_nx = RELEASE;
            end
          end else begin
            scnt_nx = scnt + SW'(1);
          end
        end
        RELEASE: begin
          if (gcnt == GW'(GAP - 1)) begin
            gcnt_nx = '0;
            for (int i = 0; i < N_OUT; i++) begin
              if (NW'(i) == stage) rst_nx[i] = 1'b1;
            end
            if (stage == NW'(N_OUT - 1)) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              stage_nx = stage + NW'(1);
            end
          end else begin
            gcnt_nx = gcnt + GW'(1);
          end
        end
        DONE: begin
          done_nx = 1'b1;
        end
        default: begin
          state_nx = HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameter sets driven together,
// checked against an elapsed-good-edge reference model.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock = 1'b0;
  logic sw = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] ra;
  logic       da, la;
  logic [0:0] rb;
  logic       db, lb;
  logic [2:0] rc;
  logic       dc, lc;

  reset_sequencer #(.N_OUT(4), .STRETCH(16), .GAP(8)) u_a (
    .clk(clk), .i_rst_async(rst), .i_lock(lock), .i_sw_rst(sw),
    .o_rst_n(ra), .o_done(da), .o_lock_lost(la)
  );

  reset_sequencer #(.N_OUT(1), .STRETCH(1), .GAP(1)) u_b (
    .clk(clk), .i_rst_async(rst), .i_lock(lock), .i_sw_rst(sw),
    .o_rst_n(rb), .o_done(db), .o_lock_lost(lb)
  );

  reset_sequencer #(.N_OUT(3), .STRETCH(3), .GAP(1)) u_c (
    .clk(clk), .i_rst_async(rst), .i_lock(lock), .i_sw_rst(sw),
    .o_rst_n(rc), .o_done(dc), .o_lock_lost(lc)
  );

  logic [13:0] obs;
  assign obs = {ra, da, la, rb, db, lb, rc, dc, lc};

  int total = 0;
  int bad = 0;

  // model state: good edges elapsed since the sequence (re)started
  int ta, tb, tc;
  logic lla, llb, llc;

  function automatic int nxt(input int t, input int s, input int g,
                             input int n, input logic r, input logic l,
                             input logic w, output logic ll);
    ll = 1'b0;
    if (!r) return 0;
    if (t < s) return (l && !w) ? t + 1 : 0;
    if (!l || w) begin
      ll = !l;
      return 0;
    end
    if (t >= s + (n - 1) * g) return t;
    return t + 1;
  endfunction

  function automatic logic [3:0] bits(input int t, input int s,
                                      input int g, input int n);
    logic [3:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k] = (t >= s + k * g);
    return b;
  endfunction

  function automatic logic [13:0] expv();
    logic [3:0] ea, eb, ec;
    ea = bits(ta, 16, 8, 4);
    eb = bits(tb, 1, 1, 1);
    ec = bits(tc, 3, 1, 3);
    return {ea, (ta >= 40), lla,
            eb[0], (tb >= 1), llb,
            ec[2:0], (tc >= 5), llc};
  endfunction

  task automatic step();
    logic r, l, w;
    r = rst;
    l = lock;
    w = sw;
    @(posedge clk);
    ta = nxt(ta, 16, 8, 4, r, l, w, lla);
    tb = nxt(tb, 1, 1, 1, r, l, w, llb);
    tc = nxt(tc, 3, 1, 3, r, l, w, llc);
    #1;
  endtask

  task automatic model_clear();
    ta = 0; tb = 0; tc = 0;
    lla = 1'b0; llb = 1'b0; llc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    lock = 1'b1;
    sw = 1'b0;
    #1 rst = 1'b0;
    model_clear();
    #1;
    total++;
    if (obs !== 14'b0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", obs, 14'b0);
    end
    step();
    step();
    total++;
    if (obs !== 14'b0) begin
      bad++;
      $display("FAIL reset_held got=%b want=%b", obs, 14'b0);
    end
    rst = 1'b1;
  endtask

  task automatic test_power_up();
    logic [3:0] wa;
    do_reset();
    lock = 1'b1;
    sw = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL pwr_model e=%0d got=%b want=%b", e, obs, expv());
      end
      if (e == 1) begin
        total++;
        if ({rb, db} !== 2'b11) begin
          bad++;
          $display("FAIL pwr_corner1 got=%b want=11", {rb, db});
        end
      end
      if (e >= 3 && e <= 5) begin
        total++;
        if (rc !== 3'((1 << (e - 2)) - 1)) begin
          bad++;
          $display("FAIL pwr_gap1 e=%0d got=%b", e, rc);
        end
      end
      if (e == 15 || e == 16 || e == 24 || e == 32 || e == 40) begin
        wa = (e == 15) ? 4'b0000 : (e == 16) ? 4'b0001 :
             (e == 24) ? 4'b0011 : (e == 32) ? 4'b0111 : 4'b1111;
        total++;
        if (ra !== wa || da !== (e == 40)) begin
          bad++;
          $display("FAIL pwr_step e=%0d got=%b/%b want=%b", e, ra, da, wa);
        end
      end
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    lock = 1'b1;
    for (int e = 1; e <= 9; e++) step();
    lock = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      total++;
      if (obs !== expv() || la !== 1'b0) begin
        bad++;
        $display("FAIL hold_lock_low got=%b want=%b", obs, expv());
      end
    end
    lock = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL hold_model e=%0d got=%b want=%b", e, obs, expv());
      end
      if (e >= 15) begin
        total++;
        if (ra !== ((e == 16) ? 4'b0001 : 4'b0000)) begin
          bad++;
          $display("FAIL hold_release e=%0d got=%b", e, ra);
        end
      end
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    lock = 1'b1;
    for (int e = 1; e <= 28; e++) step();
    total++;
    if (ra !== 4'b0011) begin
      bad++;
      $display("FAIL drop_pre got=%b want=0011", ra);
    end
    lock = 1'b0;
    step();
    total++;
    if ({ra, da, la} !== 6'b000001) begin
      bad++;
      $display("FAIL drop_abort got=%b want=000001", {ra, da, la});
    end
    lock = 1'b1;
    step();
    total++;
    if (la !== 1'b0 || obs !== expv()) begin
      bad++;
      $display("FAIL drop_pulse got=%b want=%b", obs, expv());
    end
    for (int e = 2; e <= 40; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL drop_rerun e=%0d got=%b want=%b", e, obs, expv());
      end
    end
    total++;
    if ({ra, da} !== 5'b11111) begin
      bad++;
      $display("FAIL drop_final got=%b want=11111", {ra, da});
    end
  endtask

  task automatic test_sw_rst();
    do_reset();
    lock = 1'b1;
    for (int e = 1; e <= 40; e++) step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    total++;
    if ({ra, da, la} !== 6'b0) begin
      bad++;
      $display("FAIL sw_abort got=%b want=000000", {ra, da, la});
    end
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL sw_rerun e=%0d got=%b want=%b", e, obs, expv());
      end
    end
    sw = 1'b1;
    for (int e = 0; e < 5; e++) step();
    sw = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL sw_held e=%0d got=%b want=%b", e, obs, expv());
      end
    end
    total++;
    if ({ra, da} !== 5'b11111) begin
      bad++;
      $display("FAIL sw_final got=%b want=11111", {ra, da});
    end
  endtask

  task automatic test_combined_abort();
    sw = 1'b1;
    lock = 1'b0;
    step();
    total++;
    if ({ra, la, lb, lc} !== 7'b0000111) begin
      bad++;
      $display("FAIL both_abort got=%b want=0000111", {ra, la, lb, lc});
    end
    step();
    total++;
    if ({la, lb, lc} !== 3'b000) begin
      bad++;
      $display("FAIL both_single got=%b want=000", {la, lb, lc});
    end
    sw = 1'b0;
    lock = 1'b1;
    for (int e = 1; e <= 40; e++) step();
    total++;
    if (obs !== expv()) begin
      bad++;
      $display("FAIL both_rerun got=%b want=%b", obs, expv());
    end
  endtask

  task automatic test_async_mid();
    do_reset();
    lock = 1'b1;
    for (int e = 1; e <= 32; e++) step();
    total++;
    if (ra !== 4'b0111) begin
      bad++;
      $display("FAIL async_pre got=%b want=0111", ra);
    end
    #3 rst = 1'b0;
    model_clear();
    #1;
    total++;
    if (obs !== 14'b0) begin
      bad++;
      $display("FAIL async_mid got=%b want=%b", obs, 14'b0);
    end
    step();
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL async_rerun e=%0d got=%b want=%b", e, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    int len, kind;
    for (int ep = 0; ep < 30; ep++) begin
      len = $urandom_range(1, 60);
      lock = 1'b1;
      sw = 1'b0;
      for (int c = 0; c < len; c++) begin
        step();
        total++;
        if (obs !== expv()) begin
          bad++;
          $display("FAIL rand_run ep=%0d got=%b want=%b", ep, obs, expv());
        end
      end
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        #3 rst = 1'b0;
        model_clear();
        #1;
      end else begin
        lock = (kind == 1);
        sw = (kind != 0);
      end
      len = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) begin
        step();
        total++;
        if (obs !== expv()) begin
          bad++;
          $display("FAIL rand_dist ep=%0d got=%b want=%b", ep, obs, expv());
        end
      end
      rst = 1'b1;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_power_up();
    test_lock_hold();
    test_lock_drop();
    test_sw_rst();
    test_combined_abort();
    test_async_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset-release controller sitting directly downstream of the asynchronous reset synchronizer: its reset pin is driven by the synchronizer's de-assertion-synchronized output. It stretches the incoming reset and gates release on a clock/PLL lock indication. It then releases N active-low reset outputs one at a time, in index order, with a fixed gap between them. It also accepts a synchronous software reset request that re-runs the whole sequence.

## Interface
- `N_OUT`, 4, number of sequenced reset outputs (min 1)
- `STRETCH`, 16, cycles reset is held after entry to HOLD before output 0 releases (min 1)
- `GAP`, 8, cycles between consecutive output releases (min 1)

- `clk`  input  1  clock of the destination domain
- `i_rst_async`  input  1  asynchronous, active-low reset (driven from the synchronizer output)
- `i_lock`  input  1  clock/PLL locked, synchronous to `clk`; release only proceeds while high
- `i_sw_rst`  input  1  synchronous software reset request, level-sensitive, active-high
- `o_rst_n`  output  N_OUT  sequenced active-low resets; bit 0 releases first
- `o_done`  output  1  high when all `o_rst_n` bits are released
- `o_lock_lost`  output  1  one-cycle pulse when `i_lock` falls after release has begun

## Operation
- All outputs come directly from flops; no combinational path from inputs to outputs.
- `i_rst_async` low, asynchronously: `o_rst_n` = all 0, `o_done` = 0, `o_lock_lost` = 0, state HOLD, all counters 0.
- Counter widths are derived from `STRETCH`, `GAP` and `N_OUT` (clog2, min 1 bit). No wrap-around is permitted; counters saturate or clear only as stated.
- States:
  - HOLD: all outputs asserted. Stretch counter increments each cycle while `i_lock`=1 and `i_sw_rst`=0, and clears to 0 otherwise. When it reaches STRETCH, set `o_rst_n[0]`=1, clear the gap counter, set stage index=1, and go to RELEASE (or to DONE if N_OUT=1).
  - RELEASE: gap counter increments each cycle. When it reaches GAP, set `o_rst_n[stage]`=1, increment stage and clear the gap counter. The release of bit N_OUT-1 moves to DONE.
  - DONE: `o_done`=1, hold.
- Abort (`i_sw_rst`=1 or `i_lock`=0) in RELEASE or DONE:
  - Next edge: all `o_rst_n` = 0, `o_done` = 0, go to HOLD with counters 0.
  - `o_lock_lost` pulses for that one edge only if `i_lock`=0 caused the abort, even when `i_sw_rst` is simultaneously high.
- `i_sw_rst` held high keeps the block in HOLD with the stretch counter at 0. Counting starts on the first cycle it is sampled low (given lock).
- Released bits never glitch. Once high, a bit only goes low on abort or `i_rst_async`.
- Release order is strictly ascending. Outputs satisfy the monotonic pattern (bit k high implies bit k-1 high) at all times.

## Timing
- Edge E1 is the first rising edge with `i_rst_async`, `i_lock` and `!i_sw_rst` all high and the block in HOLD.
- `o_rst_n[0]` rises at edge E(STRETCH).
- `o_rst_n[k]` rises at edge E(STRETCH + k·GAP).
- `o_done` rises at edge E(STRETCH + (N_OUT-1)·GAP), the same edge as the last bit.
- Abort latency: 1 edge from the sampled abort condition to all outputs low.
- Lock dropping for one cycle during HOLD restarts the stretch count from 0. Release then occurs STRETCH edges after lock returns.
- `o_lock_lost` is high for exactly one cycle per abort event; it never fires in HOLD.
- `i_rst_async` asserted mid-sequence: outputs low immediately, independent of `clk`. De-assertion restarts from HOLD as above.

## Test plan
- Power-up, N_OUT=4, STRETCH=16, GAP=8, lock held high: `o_rst_n` steps 0000→0001 at E16, 0011 at E24, 0111 at E32, 1111 and `o_done`=1 at E40.
- `i_lock` low for 3 cycles at E10 in HOLD → no release until 16 edges after lock returns; `o_lock_lost` stays 0.
- `i_lock` dropped at E28 (outputs 0011) → next edge 0000, `o_done`=0, `o_lock_lost` one-cycle pulse; full sequence re-runs with identical spacing.
- `i_sw_rst` pulsed 1 cycle in DONE → outputs 0000 next edge, `o_lock_lost`=0, 1111 again 40 edges after the pulse. Held 5 cycles → count starts after release.
- `i_rst_async` asserted asynchronously between edges at 0111 → `o_rst_n`=0000 with no clock edge. `i_sw_rst` and lock drop in the same cycle → single abort, one `o_lock_lost` pulse.
- Corner parameters N_OUT=1, STRETCH=1, GAP=1: `o_rst_n[0]` and `o_done` rise at E1. N_OUT=3, GAP=1: bits release on consecutive edges.
